// File: rtl/spdif_pkg.sv
// Shared types and slot indices for the S/PDIF subframe decoder.
package spdif_pkg;

  typedef enum logic [1:0] {
    CLS_T1,
    CLS_T2,
    CLS_T3,
    CLS_ERR
  } cls_e;

  typedef enum logic [1:0] {
    PRE_B,
    PRE_M,
    PRE_W
  } pre_e;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_PRE,
    ST_BIT_A,
    ST_BIT_B
  } state_e;

  localparam int AUX_LSB   = 4;
  localparam int AUD_MSB   = 27;
  localparam int V         = 28;
  localparam int U         = 29;
  localparam int C         = 30;
  localparam int P         = 31;
  localparam int SLOT_BITS = P - AUX_LSB + 1;

endpackage

// File: rtl/spdif_subframe_decoder_if.sv
// Edge input and decoded-sample outputs of the subframe decoder.
interface spdif_subframe_decoder_if;

  logic        rx_edge;
  logic [23:0] sample_data;
  logic        sample_valid;
  logic        sample_right;
  logic        block_start;
  logic        validity_bit;
  logic        user_bit;
  logic        chan_status;
  logic        audio_locked;
  logic        frame_err;

  modport master (
    input  rx_edge,
    output sample_data, sample_valid, sample_right, block_start,
           validity_bit, user_bit, chan_status, audio_locked, frame_err
  );

  modport slave (
    output rx_edge,
    input  sample_data, sample_valid, sample_right, block_start,
           validity_bit, user_bit, chan_status, audio_locked, frame_err
  );

endinterface

// File: rtl/spdif_subframe_decoder_classifier.sv
// Measures the gap between rx_edge pulses and classifies it as T1/T2/T3 or ERR.
// A missing edge is reported once, in the cycle the count first exceeds T3_MAX.
module spdif_interval_classifier
  import spdif_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int T1_MIN = 5,
  parameter int T1_MAX = 11,
  parameter int T2_MAX = 19,
  parameter int T3_MAX = 27
) (
  input  logic clk_in,
  input  logic reset,
  input  logic rx_edge_i,
  output logic cls_valid_o,
  output cls_e cls_o
);

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] T1Min     = CNT_W'(T1_MIN);
  localparam logic [CNT_W-1:0] T1Max     = CNT_W'(T1_MAX);
  localparam logic [CNT_W-1:0] T2Max     = CNT_W'(T2_MAX);
  localparam logic [CNT_W-1:0] T3Max     = CNT_W'(T3_MAX);
  localparam logic [CNT_W-1:0] TimeoutAt = CNT_W'(T3_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CntMax) cnt_d = cnt_q;
    if (rx_edge_i)       cnt_d = CNT_W'(1);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // An edge landing on the timeout count sees the same ERR, so only one event results.
  assign timeout     = (cnt_q == TimeoutAt);
  assign cls_valid_o = rx_edge_i | timeout;

  always_comb begin
    if (cnt_q < T1Min || cnt_q > T3Max) cls_o = CLS_ERR;
    else if (cnt_q <= T1Max)            cls_o = CLS_T1;
    else if (cnt_q <= T2Max)            cls_o = CLS_T2;
    else                                cls_o = CLS_T3;
  end

endmodule

// File: rtl/spdif_subframe_decoder.sv
// S/PDIF subframe decoder: preamble detection, biphase-mark slot decode, parity,
// lock tracking and registered sample outputs.
module spdif_subframe_decoder
  import spdif_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int T1_MIN     = 5,
  parameter int T1_MAX     = 11,
  parameter int T2_MAX     = 19,
  parameter int T3_MAX     = 27,
  parameter int LOCK_SUBFR = 4
) (
  input  logic clk_in,
  input  logic reset,
  spdif_subframe_decoder_if.master bus
);

  localparam int               LOCK_W     = $clog2(LOCK_SUBFR + 1);
  localparam logic [LOCK_W-1:0] LockTarget = LOCK_W'(LOCK_SUBFR);

  logic                 clsValid;
  cls_e                 cls;
  state_e               state_q;
  logic [1:0]           preCnt_q;
  cls_e                 gap1_q, gap2_q;
  logic                 isRight_q, isBlock_q;
  logic [SLOT_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [4:0]           slot_q;
  logic [LOCK_W-1:0]    lockCnt_q;
  logic [23:0]          sampleData_q;
  logic                 sampleValid_q, sampleRight_q, blockStart_q;
  logic                 validity_q, user_q, chanStatus_q, locked_q, frameErr_q;

  logic                 preHit;
  pre_e                 preKind;
  logic                 doShift, bitVal, doFail, lastSlot, parityOk;
  logic [SLOT_BITS-1:0] fullWord;
  logic [LOCK_W-1:0]    lockNext;
  logic                 unusedShift;

  spdif_interval_classifier #(
    .CNT_W (CNT_W),
    .T1_MIN(T1_MIN),
    .T1_MAX(T1_MAX),
    .T2_MAX(T2_MAX),
    .T3_MAX(T3_MAX)
  ) u_classifier (
    .clk_in     (clk_in),
    .reset      (reset),
    .rx_edge_i  (bus.rx_edge),
    .cls_valid_o(clsValid),
    .cls_o      (cls)
  );

  // The leading T3 is implied; gap1/gap2 plus the current gap identify the preamble.
  always_comb begin
    preHit  = 1'b0;
    preKind = PRE_B;
    if (gap1_q == CLS_T1 && gap2_q == CLS_T1 && cls == CLS_T3) begin
      preHit = 1'b1;
    end else if (gap1_q == CLS_T3 && gap2_q == CLS_T1 && cls == CLS_T1) begin
      preHit  = 1'b1;
      preKind = PRE_M;
    end else if (gap1_q == CLS_T2 && gap2_q == CLS_T1 && cls == CLS_T2) begin
      preHit  = 1'b1;
      preKind = PRE_W;
    end
  end

  always_comb begin
    doShift = 1'b0;
    bitVal  = 1'b0;
    doFail  = 1'b0;
    if (clsValid) begin
      case (state_q)
        ST_HUNT: doFail = 1'b0;
        ST_PRE: begin
          if (preCnt_q == 2'd0)      doFail = (cls != CLS_T3);
          else if (cls == CLS_ERR)   doFail = 1'b1;
          else if (preCnt_q == 2'd3) doFail = !preHit;
        end
        ST_BIT_A: begin
          doShift = (cls == CLS_T2);
          doFail  = (cls == CLS_T3) || (cls == CLS_ERR);
        end
        ST_BIT_B: begin
          bitVal  = 1'b1;
          doShift = (cls == CLS_T1);
          doFail  = (cls != CLS_T1);
        end
        default: doFail = 1'b1;
      endcase
    end
  end

  // Slot 4 enters first and ends up at bit 0 after all 28 shifts.
  assign fullWord    = {bitVal, shift_q[SLOT_BITS-1:1]};
  assign lastSlot    = doShift && (slot_q == 5'(P));
  assign parityOk    = !(parity_q ^ bitVal);
  assign lockNext    = (lockCnt_q == LockTarget) ? lockCnt_q : lockCnt_q + 1'b1;
  assign unusedShift = shift_q[0];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      preCnt_q      <= 2'd0;
      gap1_q        <= CLS_T1;
      gap2_q        <= CLS_T1;
      isRight_q     <= 1'b0;
      isBlock_q     <= 1'b0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      slot_q        <= 5'd0;
      lockCnt_q     <= '0;
      sampleData_q  <= '0;
      sampleValid_q <= 1'b0;
      sampleRight_q <= 1'b0;
      blockStart_q  <= 1'b0;
      validity_q    <= 1'b0;
      user_q        <= 1'b0;
      chanStatus_q  <= 1'b0;
      locked_q      <= 1'b0;
      frameErr_q    <= 1'b0;
    end else begin
      sampleValid_q <= 1'b0;
      frameErr_q    <= 1'b0;

      if (clsValid && !doFail) begin
        case (state_q)
          ST_HUNT: begin
            if (cls == CLS_T3) begin
              state_q  <= ST_PRE;
              preCnt_q <= 2'd1;
            end
          end
          ST_PRE: begin
            preCnt_q <= preCnt_q + 2'd1;
            if (preCnt_q == 2'd1) gap1_q <= cls;
            if (preCnt_q == 2'd2) gap2_q <= cls;
            if (preCnt_q == 2'd3) begin
              isRight_q <= (preKind == PRE_W);
              isBlock_q <= (preKind == PRE_B);
              shift_q   <= '0;
              parity_q  <= 1'b0;
              slot_q    <= 5'(AUX_LSB);
              state_q   <= ST_BIT_A;
            end
          end
          ST_BIT_A: if (cls == CLS_T1) state_q <= ST_BIT_B;
          ST_BIT_B: state_q <= ST_BIT_A;
          default:  state_q <= ST_HUNT;
        endcase
      end

      // Framing is intact once slot 31 arrives, so a parity failure still re-enters PRE.
      if (doShift) begin
        shift_q  <= fullWord;
        parity_q <= parity_q ^ bitVal;
        slot_q   <= slot_q + 5'd1;
        if (lastSlot) begin
          state_q  <= ST_PRE;
          preCnt_q <= 2'd0;
          if (parityOk) begin
            sampleValid_q <= 1'b1;
            sampleData_q  <= fullWord[AUD_MSB-AUX_LSB:0];
            validity_q    <= fullWord[V-AUX_LSB];
            user_q        <= fullWord[U-AUX_LSB];
            chanStatus_q  <= fullWord[C-AUX_LSB];
            sampleRight_q <= isRight_q;
            blockStart_q  <= isBlock_q;
            lockCnt_q     <= lockNext;
            locked_q      <= (lockNext == LockTarget);
          end else begin
            frameErr_q <= 1'b1;
            lockCnt_q  <= '0;
            locked_q   <= 1'b0;
          end
        end
      end

      if (doFail) begin
        frameErr_q <= 1'b1;
        lockCnt_q  <= '0;
        locked_q   <= 1'b0;
        state_q    <= ST_HUNT;
      end
    end
  end

  assign bus.sample_data  = sampleData_q;
  assign bus.sample_valid = sampleValid_q;
  assign bus.sample_right = sampleRight_q;
  assign bus.block_start  = blockStart_q;
  assign bus.validity_bit = validity_q;
  assign bus.user_bit     = user_q;
  assign bus.chan_status  = chanStatus_q;
  assign bus.audio_locked = locked_q;
  assign bus.frame_err    = frameErr_q;

endmodule
